debug_seg_pager: RTL and testbench

- Paged debug readout for the seven-segment bank.
- Drives N_DIG digits from one of N_CH selectable debug channels, replacing hard-wired per-digit debug nibble assignments in the top level.
- Page selection is manual (debounced button) or automatic (timed rotation).
- A freeze button snapshots all channels so fast-changing camera/SCCB state can be read at leisure.
- Sits between the functional blocks' debug buses and the board LED pins; segment encoding is produced by per-digit `dig_ctrl` instances.

---
 rtl/debug_seg_pager_if.sv | 17 +
 rtl/debug_seg_pager.sv | 115 +++++++++++
 tb/tb_debug_seg_pager.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_seg_pager_if.sv
// debug_seg_pager_if: channel data, buttons and display outputs of the paged
// seven-segment debug readout.
interface debug_seg_pager_if #(
    parameter int N_DIG = 8,
    parameter int N_CH  = 4
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    logic [4*N_DIG*N_CH-1:0] ch_data;
    logic                    btn_next;
    logic                    btn_freeze;
    logic                    auto_en;
    logic [7*N_DIG-1:0]      led;
    logic [PW-1:0]           page;
    logic                    frozen;
    modport master (output ch_data, btn_next, btn_freeze, auto_en, input led, page, frozen);
    modport slave (input ch_data, btn_next, btn_freeze, auto_en, output led, page, frozen);
endinterface

// File: rtl/debug_seg_pager.sv
// debug_seg_pager: paged seven-segment debug readout with debounced paging/freeze buttons.
// Timed auto rotation is built only when AUTO_ROTATE_EN is defined.
module dig_ctrl (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    // Active-high segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] LUT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };
    assign seg = LUT[nib];
endmodule

module seg_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          diff;
    logic          done;
    assign diff  = sync[1] != acc;
    assign done  = diff && (cnt == CW'(DEB_CYCLES));
    assign pulse = done && sync[1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            acc  <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            cnt  <= (!diff || done) ? '0 : cnt + 1'b1;
            if (done) acc <= sync[1];
        end
    end
endmodule

module debug_seg_pager #(
    parameter int N_DIG       = 8,
    parameter int N_CH        = 4,
    parameter int DEB_CYCLES  = 65536,
    parameter int AUTO_CYCLES = 25000000
) (
    input logic clk,
    input logic rst,
    debug_seg_pager_if.slave bus
);
    localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW = 4 * N_DIG;
    logic              next_p;
    logic              frz_p;
    logic              tick;
    logic [PW-1:0]     page;
    logic [PW-1:0]     page_nxt;
    logic              frozen;
    logic [DW*N_CH-1:0] live;
    logic [DW*N_CH-1:0] snap;
    logic [DW*N_CH-1:0] src;
    logic [DW-1:0]     disp;

    seg_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk(clk), .rst(rst), .raw(bus.btn_next), .pulse(next_p));
    seg_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_frz (.clk(clk), .rst(rst), .raw(bus.btn_freeze), .pulse(frz_p));

`ifdef AUTO_ROTATE_EN
    localparam int TW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    logic [1:0]    auto_sync;
    logic [TW-1:0] tmr;
    assign tick = auto_sync[1] && !frozen && (tmr == TW'(AUTO_CYCLES - 1));
    // A manual advance restarts the dwell so the new page gets a full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_sync <= '0;
            tmr       <= '0;
        end else begin
            auto_sync <= {auto_sync[0], bus.auto_en};
            tmr       <= (!auto_sync[1] || frozen || next_p || tick) ? '0 : tmr + 1'b1;
        end
    end
`else
    assign tick = 1'b0;
`endif

    assign page_nxt = (N_CH == 1 || page == PW'(N_CH - 1)) ? '0 : page + 1'b1;
    assign src      = frozen ? snap : live;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page   <= '0;
            frozen <= 1'b0;
            live   <= '0;
            snap   <= '0;
            disp   <= '0;
        end else begin
            live <= bus.ch_data;
            if (next_p || tick) page <= page_nxt;
            if (frz_p) frozen <= !frozen;
            if (frz_p && !frozen) snap <= bus.ch_data;
            disp <= src[DW*int'(page) +: DW];
        end
    end

    assign bus.page   = page;
    assign bus.frozen = frozen;

    for (genvar d = 0; d < N_DIG; d++) begin : g_dig
        dig_ctrl u_dig (.nib(disp[4*d +: 4]), .seg(bus.led[7*d +: 7]));
    end
endmodule

// File: tb/tb_debug_seg_pager.sv
// tb_debug_seg_pager: directed and randomized checks of paging, debounce,
// auto rotation, freeze and reset against a behavioural page/display model.
module tb_debug_seg_pager;
    localparam int N_DIG = 8;
    localparam int N_CH  = 4;
    localparam int DEB   = 4;
    localparam int AUTO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    debug_seg_pager_if #(.N_DIG(N_DIG), .N_CH(N_CH)) bus ();
    debug_seg_pager #(.N_DIG(N_DIG), .N_CH(N_CH), .DEB_CYCLES(DEB), .AUTO_CYCLES(AUTO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_page = 0;
    logic [127:0] data;
    logic [127:0] snap;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'ha: return 7'b1110111;
            4'hb: return 7'b1111100;
            4'hc: return 7'b0111001;
            4'hd: return 7'b1011110;
            4'he: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    function automatic logic [55:0] show(input logic [127:0] src, input int pg);
        logic [55:0] r;
        logic [31:0] ch;
        ch = src[32*pg +: 32];
        for (int d = 0; d < N_DIG; d++) r[7*d +: 7] = seg7(ch[4*d +: 4]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold);
        bus.btn_next = 1'b1;
        step(hold);
        bus.btn_next = 1'b0;
        step(12);
        exp_page = (exp_page + 1) % N_CH;
    endtask

    task automatic go_page(input int p);
        while (exp_page != p) press(6);
    endtask

    task automatic press_freeze();
        bus.btn_freeze = 1'b1;
        step(7);
        bus.btn_freeze = 1'b0;
        step(12);
    endtask

    task automatic chk_view(input string tag, input logic [127:0] src);
        check({tag, " page"}, 64'(bus.page), 64'(exp_page));
        check({tag, " led"}, 64'(bus.led), 64'(show(src, exp_page)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        data = {32'h13579bdf, 32'hfedcba98, 32'h89abcdef, 32'h00000000};
        bus.ch_data = data;
        bus.btn_next = 1'b0;
        bus.btn_freeze = 1'b0;
        bus.auto_en = 1'b0;
        step(3);
        check("reset page", 64'(bus.page), 64'd0);
        check("reset frozen", 64'(bus.frozen), 64'd0);
        check("reset led", 64'(bus.led), 64'(show('0, 0)));
        rst = 1'b0;
        step(3);
        chk_view("live idle", data);

        // Live latency: two edges from applying ch_data to led
        data[31:0] = 32'h01234567;
        bus.ch_data = data;
        step(1);
        check("live lat1", 64'(bus.led), 64'(show({data[127:32], 32'h0}, 0)));
        step(1);
        chk_view("live lat2", data);

        // Bounce never accepted
        bus.btn_next = 1'b1; step(3);
        bus.btn_next = 1'b0; step(1);
        bus.btn_next = 1'b1; step(1);
        bus.btn_next = 1'b0; step(12);
        chk_view("bounce", data);

        // Clean hold: page changes DEB+2 cycles after first sampling edge
        bus.btn_next = 1'b1;
        step(6);
        check("hold pre", 64'(bus.page), 64'd0);
        step(1);
        check("hold edge", 64'(bus.page), 64'd1);
        check("hold led old", 64'(bus.led), 64'(show(data, 0)));
        step(1);
        check("hold led new", 64'(bus.led), 64'(show(data, 1)));
        step(2);
        bus.btn_next = 1'b0;
        step(12);
        exp_page = 1;
        chk_view("hold once", data);

        go_page(3);
        for (int i = 0; i < 4; i++) begin
            press(6 + i);
            chk_view("wrap", data);
        end

        for (int i = 0; i < 10; i++) begin
            int act;
            int len;
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.ch_data = data;
            step(2);
            chk_view("rand data", data);
            act = int'($urandom_range(2));
            if (act == 1) begin
                len = int'($urandom_range(3, 1));
                bus.btn_next = 1'b1; step(len);
                bus.btn_next = 1'b0; step(12);
            end else if (act == 2) begin
                press(int'($urandom_range(10, 6)));
            end
            chk_view("rand act", data);
        end

`ifdef AUTO_ROTATE_EN
        begin
            int p;
            p = exp_page;
            bus.auto_en = 1'b1;
            step(17);
            check("auto t17", 64'(bus.page), 64'(p));
            step(1);
            check("auto t18", 64'(bus.page), 64'((p + 1) % N_CH));
            step(14);
            check("auto t32", 64'(bus.page), 64'((p + 1) % N_CH));
            bus.btn_next = 1'b1;
            step(2);
            check("auto t34", 64'(bus.page), 64'((p + 2) % N_CH));
            step(4);
            check("auto t38", 64'(bus.page), 64'((p + 2) % N_CH));
            step(1);
            check("manual t39", 64'(bus.page), 64'((p + 3) % N_CH));
            step(1);
            bus.btn_next = 1'b0;
            step(14);
            check("restart t54", 64'(bus.page), 64'((p + 3) % N_CH));
            step(1);
            check("restart t55", 64'(bus.page), 64'(p % N_CH));
            bus.auto_en = 1'b0;
            step(12);
        end
        go_page(3);
        bus.auto_en = 1'b1;
        step(11);
        bus.btn_next = 1'b1;
        step(6);
        check("coinc pre", 64'(bus.page), 64'd3);
        step(1);
        check("coinc edge", 64'(bus.page), 64'd0);
        bus.auto_en = 1'b0;
        bus.btn_next = 1'b0;
        step(12);
        exp_page = 0;
        chk_view("coinc after", data);
`else
        bus.auto_en = 1'b1;
        step(40);
        bus.auto_en = 1'b0;
        step(4);
        chk_view("auto ignored", data);
`endif

        go_page(1);
        data[63:32] = 32'hdeadbeef;
        bus.ch_data = data;
        step(2);
        bus.btn_freeze = 1'b1;
        step(6);
        check("freeze pre", 64'(bus.frozen), 64'd0);
        step(1);
        check("freeze edge", 64'(bus.frozen), 64'd1);
        snap = data;
        bus.btn_freeze = 1'b0;
        step(12);
        data[63:32] = 32'h0;
        data[95:64] = ~data[95:64];
        bus.ch_data = data;
        step(3);
        chk_view("frozen hold", snap);
        bus.auto_en = 1'b1;
        step(40);
        bus.auto_en = 1'b0;
        step(4);
        chk_view("frozen paused", snap);
        press(6);
        chk_view("frozen page2", snap);
        press_freeze();
        check("unfreeze", 64'(bus.frozen), 64'd0);
        chk_view("unfrozen live", data);

        // Asynchronous reset between edges while rotating and frozen
        go_page(2);
        bus.auto_en = 1'b1;
        step(25);
        press_freeze();
        check("pre-reset frozen", 64'(bus.frozen), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("async rst page", 64'(bus.page), 64'd0);
        check("async rst frozen", 64'(bus.frozen), 64'd0);
        check("async rst led", 64'(bus.led), 64'(show('0, 0)));
        step(3);
        check("rst hold page", 64'(bus.page), 64'd0);
        check("rst hold led", 64'(bus.led), 64'(show('0, 0)));
        rst = 1'b0;
        exp_page = 0;
        step(2);
        chk_view("post reset", data);
        check("post reset frozen", 64'(bus.frozen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
